// File: rtl/spi_param_ram_if.sv
// rtl/spi_param_ram_if.sv - command/response bus between the SPI slave and spi_param_ram
interface spi_param_ram_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH+1:0] din;
    logic                  rx_valid;
    logic [ADDR_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  seq_err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  seq_err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output seq_err
    );
endinterface

// File: rtl/spi_param_ram.sv
// rtl/spi_param_ram.sv - command-tagged single-port RAM behind the SPI slave; optional SPI_RAM_AUTO_INC_EN burst addressing
module spi_param_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_param_ram_if.slave    bus
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int unsigned DEPTH_U = MEM_DEPTH;

`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    // Burst pointers wrap at the configured depth, not at the address-space size.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction
`endif

    logic [1:0]            cmd;
    logic [ADDR_WIDTH-1:0] payload;
    logic                  payload_ok;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_armed;
    logic                  rd_armed;

    logic [ADDR_WIDTH-1:0] wr_addr_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr_nxt;
    logic                  wr_armed_nxt;
    logic                  rd_armed_nxt;
    logic                  wr_data_ok;
    logic                  rd_data_ok;
    logic                  reject;

    logic [ADDR_WIDTH-1:0] dout_q;
    logic                  tx_valid_q;
    logic                  seq_err_q;

    logic [ADDR_WIDTH-1:0] mem [MEM_DEPTH];

    assign cmd        = bus.din[ADDR_WIDTH+1:ADDR_WIDTH];
    assign payload    = bus.din[ADDR_WIDTH-1:0];
    assign payload_ok = (32'(payload) < DEPTH_U);

    // Decode one command per valid cycle into pointer/arming updates and accept/reject strobes.
    always_comb begin
        wr_addr_nxt  = wr_addr;
        rd_addr_nxt  = rd_addr;
        wr_armed_nxt = wr_armed;
        rd_armed_nxt = rd_armed;
        wr_data_ok   = 1'b0;
        rd_data_ok   = 1'b0;
        reject       = 1'b0;
        if (bus.rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    if (payload_ok) begin
                        wr_addr_nxt  = payload;
                        wr_armed_nxt = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                CMD_WR_DATA: begin
                    if (wr_armed) begin
                        wr_data_ok = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                        wr_addr_nxt = next_addr(wr_addr);
`endif
                    end else begin
                        reject = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    if (payload_ok) begin
                        rd_addr_nxt  = payload;
                        rd_armed_nxt = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    if (rd_armed) begin
                        rd_data_ok = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                        rd_addr_nxt = next_addr(rd_addr);
`endif
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: reject = 1'b0;
            endcase
        end
    end

    // Control state and registered responses; reset drops any arming so bursts must restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            wr_armed   <= 1'b0;
            rd_armed   <= 1'b0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            wr_addr    <= wr_addr_nxt;
            rd_addr    <= rd_addr_nxt;
            wr_armed   <= wr_armed_nxt;
            rd_armed   <= rd_armed_nxt;
            tx_valid_q <= rd_data_ok;
            seq_err_q  <= reject;
            if (rd_data_ok) begin
                dout_q <= mem[rd_addr];
            end
        end
    end

    // Storage array has no reset so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (wr_data_ok) begin
            mem[wr_addr] <= payload;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_param_ram.sv
// tb/tb_spi_param_ram.sv - scoreboard bench for spi_param_ram with a behavioural memory model
module tb_spi_param_ram;

    localparam int AW    = 8;
    localparam int DEPTH = 200;

    typedef struct {
        int         due;
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [1:0] mon_kind;
    logic [7:0] last_dout;

    logic [7:0] m_mem [0:255];
    int         m_wa;
    int         m_ra;
    bit         m_wa_armed;
    bit         m_ra_armed;

    spi_param_ram_if #(.ADDR_WIDTH(AW)) bus ();

    spi_param_ram #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    task automatic push_err();
        exp_q.push_back('{due: cyc + 1, is_err: 1'b1, data: 8'h00});
    endtask

    task automatic model(input logic [1:0] c, input logic [7:0] p);
        case (c)
            2'b00: if (int'(p) < DEPTH) begin m_wa = p; m_wa_armed = 1; end else push_err();
            2'b10: if (int'(p) < DEPTH) begin m_ra = p; m_ra_armed = 1; end else push_err();
            2'b01: begin
                if (m_wa_armed) begin
                    m_mem[m_wa] = p;
`ifdef SPI_RAM_AUTO_INC_EN
                    m_wa = (m_wa + 1) % DEPTH;
`endif
                end else push_err();
            end
            default: begin
                if (m_ra_armed) begin
                    exp_q.push_back('{due: cyc + 1, is_err: 1'b0, data: m_mem[m_ra]});
`ifdef SPI_RAM_AUTO_INC_EN
                    m_ra = (m_ra + 1) % DEPTH;
`endif
                end else push_err();
            end
        endcase
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] p);
        bus.din      = {c, p};
        bus.rx_valid = 1'b1;
        model(c, p);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        bus.din      = 10'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mid_cycle_reset();
        #1;
        rst_n      = 1'b0;
        m_wa       = 0;
        m_ra       = 0;
        m_wa_armed = 0;
        m_ra_armed = 0;
        exp_q.delete();
        last_dout  = 8'h00;
        #1;
        check("reset_dout", bus.dout, 0);
        check("reset_tx_valid", bus.tx_valid, 0);
        check("reset_seq_err", bus.seq_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Every non-reset cycle: the pulse due now (if any) must appear, nothing else may, and dout must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_kind = 2'b00;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e    = exp_q.pop_front();
                mon_kind = mon_e.is_err ? 2'b01 : 2'b10;
                if (!mon_e.is_err) last_dout = mon_e.data;
            end
            check("pulse_tx_err", {bus.tx_valid, bus.seq_err}, mon_kind);
            check("dout", bus.dout, last_dout);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.din      = '0;
        last_dout    = 8'h00;
        m_wa = 0; m_ra = 0; m_wa_armed = 0; m_ra_armed = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Read without arming after reset.
        issue(2'b11, 8'h00);
        idle(1);

        // Fill every legal word so later reads have defined contents.
        for (int a = 0; a < DEPTH; a++) begin
            issue(2'b00, 8'(a));
            issue(2'b01, 8'($urandom));
        end

        // Basic write/read and back-to-back reads.
        issue(2'b00, 8'h10);
        issue(2'b01, 8'h5A);
        issue(2'b10, 8'h10);
        issue(2'b11, 8'h00);
        idle(1);
        issue(2'b10, 8'h10);
        issue(2'b11, 8'h00);
        issue(2'b11, 8'h00);
        idle(2);

        // Range boundary: 0xC8 rejected, prior wr_addr still used; 0xC7 legal.
        issue(2'b00, 8'h20);
        issue(2'b00, 8'hC8);
        issue(2'b01, 8'h77);
        issue(2'b10, 8'h20);
        issue(2'b11, 8'h00);
        issue(2'b10, 8'hC7);
        issue(2'b11, 8'h00);
        issue(2'b10, 8'hFF);
        idle(1);

        // Burst near the top of memory (wraps when auto-increment is built in).
        issue(2'b00, 8'(DEPTH - 2));
        issue(2'b01, 8'h01);
        issue(2'b01, 8'h02);
        issue(2'b01, 8'h03);
        issue(2'b10, 8'(DEPTH - 2));
        issue(2'b11, 8'h00);
        issue(2'b11, 8'h00);
        issue(2'b11, 8'h00);
        issue(2'b10, 8'h00);
        issue(2'b11, 8'h00);
        idle(1);

        // Reset during a read response, then data command without re-arming.
        issue(2'b10, 8'h10);
        issue(2'b11, 8'h00);
        mid_cycle_reset();
        issue(2'b01, 8'hAA);
        issue(2'b11, 8'h00);
        idle(1);
        issue(2'b10, 8'h00);
        issue(2'b11, 8'h00);
        idle(1);

        // Randomised traffic with gaps and one reset in the middle.
        for (int i = 0; i < 1200; i++) begin
            if (i == 600) mid_cycle_reset();
            if ($urandom_range(0, 9) < 3) idle(1);
            else issue(2'($urandom), 8'($urandom));
        end

        idle(3);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
